// File: rtl/mem_access_unit.sv
// Load/store stage: one memory op at a time over a req/ack word memory, with lane steering,
// load extension and LWL/LWR merging. Define MEM_ALIGN_EXC_EN to trap misaligned lw/sw/lh/lhu/sh.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DEST_W = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [4:0]        st_pick,
  input  logic [6:0]        ld_pick,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       st_data,
  input  logic [31:0]       rt_old,
  input  logic [DEST_W-1:0] dest,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wen,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_exc
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;
  typedef enum logic [3:0] {
    OP_NONE, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR,
    OP_SW, OP_SH, OP_SB, OP_SWL, OP_SWR
  } op_e;

  state_e            state_q, state_d;
  op_e               opKind_q, opKind_d, accOp;
  logic [1:0]        lane_q, lane_d, lane;
  logic [31:0]       rtOld_q, rtOld_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [3:0]        memWen_q, memWen_d, storeWen;
  logic [31:0]       memWdata_q, memWdata_d, storeWdata;
  logic [31:0]       wbData_q, wbData_d, loadData;
  logic [DEST_W-1:0] wbDest_q, wbDest_d;
  logic [4:0]        shAmt;
  logic [7:0]        byteSel;
  logic [15:0]       halfSel;
  logic              opIsLoad;

  // Any load bit beats any store bit; lowest index wins inside each vector.
  always_comb begin
    accOp = OP_NONE;
    if      (ld_pick[0]) accOp = OP_LW;
    else if (ld_pick[1]) accOp = OP_LB;
    else if (ld_pick[2]) accOp = OP_LBU;
    else if (ld_pick[3]) accOp = OP_LH;
    else if (ld_pick[4]) accOp = OP_LHU;
    else if (ld_pick[5]) accOp = OP_LWL;
    else if (ld_pick[6]) accOp = OP_LWR;
    else if (st_pick[0]) accOp = OP_SW;
    else if (st_pick[1]) accOp = OP_SH;
    else if (st_pick[2]) accOp = OP_SB;
    else if (st_pick[3]) accOp = OP_SWL;
    else if (st_pick[4]) accOp = OP_SWR;
  end

  always_comb begin
    lane       = addr[1:0];
    shAmt      = {lane, 3'b000};
    storeWen   = 4'b0000;
    storeWdata = 32'h0;
    case (accOp)
      OP_SW: begin storeWen = 4'b1111; storeWdata = st_data; end
      OP_SH: begin
        storeWen   = lane[1] ? 4'b1100 : 4'b0011;
        storeWdata = {2{st_data[15:0]}};
      end
      OP_SB: begin storeWen = 4'b0001 << lane; storeWdata = {4{st_data[7:0]}}; end
      OP_SWL: begin
        case (lane)
          2'd0:    storeWen = 4'b0001;
          2'd1:    storeWen = 4'b0011;
          2'd2:    storeWen = 4'b0111;
          default: storeWen = 4'b1111;
        endcase
        storeWdata = st_data >> (5'd24 - shAmt);
      end
      OP_SWR: begin storeWen = 4'b1111 << lane; storeWdata = st_data << shAmt; end
      default: ;
    endcase
  end

  always_comb begin
    byteSel  = mem_rdata[{lane_q, 3'b000} +: 8];
    halfSel  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    loadData = mem_rdata;
    opIsLoad = (opKind_q inside {OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR});
    case (opKind_q)
      OP_LB:  loadData = {{24{byteSel[7]}}, byteSel};
      OP_LBU: loadData = {24'h0, byteSel};
      OP_LH:  loadData = {{16{halfSel[15]}}, halfSel};
      OP_LHU: loadData = {16'h0, halfSel};
      OP_LWL: begin
        case (lane_q)
          2'd0:    loadData = {mem_rdata[7:0],  rtOld_q[23:0]};
          2'd1:    loadData = {mem_rdata[15:0], rtOld_q[15:0]};
          2'd2:    loadData = {mem_rdata[23:0], rtOld_q[7:0]};
          default: loadData = mem_rdata;
        endcase
      end
      OP_LWR: begin
        case (lane_q)
          2'd0:    loadData = mem_rdata;
          2'd1:    loadData = {rtOld_q[31:24], mem_rdata[31:8]};
          2'd2:    loadData = {rtOld_q[31:16], mem_rdata[31:16]};
          default: loadData = {rtOld_q[31:8],  mem_rdata[31:24]};
        endcase
      end
      default: ;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  logic wbExc_q, wbExc_d, misaligned;
  always_comb begin
    misaligned = ((accOp == OP_LW || accOp == OP_SW) && (addr[1:0] != 2'b00)) ||
                 ((accOp == OP_LH || accOp == OP_LHU || accOp == OP_SH) && addr[0]);
  end
  assign wb_exc = wbExc_q;
`else
  assign wb_exc = 1'b0;
`endif

  // Next-state logic; op fields are latched only on accept so the memory side stays stable.
  always_comb begin
    state_d    = state_q;
    opKind_d   = opKind_q;
    lane_d     = lane_q;
    rtOld_d    = rtOld_q;
    memAddr_d  = memAddr_q;
    memWen_d   = memWen_q;
    memWdata_d = memWdata_q;
    wbData_d   = wbData_q;
    wbDest_d   = wbDest_q;
`ifdef MEM_ALIGN_EXC_EN
    wbExc_d    = wbExc_q;
`endif
    op_ready   = (state_q == ST_IDLE);
    mem_req    = (state_q == ST_REQ);
    wb_valid   = (state_q == ST_RESP);
    case (state_q)
      ST_IDLE: begin
        if (op_valid && accOp != OP_NONE) begin
          state_d    = ST_REQ;
          opKind_d   = accOp;
          lane_d     = lane;
          rtOld_d    = rt_old;
          memAddr_d  = {addr[ADDR_W-1:2], 2'b00};
          memWen_d   = storeWen;
          memWdata_d = storeWdata;
          wbDest_d   = dest;
`ifdef MEM_ALIGN_EXC_EN
          wbExc_d    = misaligned;
          if (misaligned) begin
            state_d  = ST_RESP;
            wbData_d = 32'(addr);
          end
`endif
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          if (opIsLoad) begin
            state_d  = ST_RESP;
            wbData_d = loadData;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_RESP: if (wb_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      opKind_q   <= OP_NONE;
      lane_q     <= 2'b00;
      rtOld_q    <= 32'h0;
      memAddr_q  <= '0;
      memWen_q   <= 4'b0000;
      memWdata_q <= 32'h0;
      wbData_q   <= 32'h0;
      wbDest_q   <= '0;
`ifdef MEM_ALIGN_EXC_EN
      wbExc_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      opKind_q   <= opKind_d;
      lane_q     <= lane_d;
      rtOld_q    <= rtOld_d;
      memAddr_q  <= memAddr_d;
      memWen_q   <= memWen_d;
      memWdata_q <= memWdata_d;
      wbData_q   <= wbData_d;
      wbDest_q   <= wbDest_d;
`ifdef MEM_ALIGN_EXC_EN
      wbExc_q    <= wbExc_d;
`endif
    end
  end

  assign mem_addr  = memAddr_q;
  assign mem_wen   = memWen_q;
  assign mem_wdata = memWdata_q;
  assign wb_data   = wbData_q;
  assign wb_dest   = wbDest_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: inputs driven and outputs sampled 1ns after each rising edge.
module tb_mem_access_unit;
  localparam int ADDR_W = 32;
  localparam int DEST_W = 5;

  logic              clk = 1'b0;
  logic              resetn;
  logic              op_valid, op_ready;
  logic [4:0]        st_pick;
  logic [6:0]        ld_pick;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       st_data, rt_old;
  logic [DEST_W-1:0] dest;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wen;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic              wb_valid, wb_ready;
  logic [31:0]       wb_data;
  logic [DEST_W-1:0] wb_dest;
  logic              wb_exc;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W), .DEST_W(DEST_W)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_ready(op_ready),
    .st_pick(st_pick), .ld_pick(ld_pick), .addr(addr), .st_data(st_data),
    .rt_old(rt_old), .dest(dest), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_exc(wb_exc)
  );

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle; the unit must be idle when offered.
  task automatic applyStimulus(input logic [6:0] ld, input logic [4:0] st, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] rt, input logic [4:0] d);
    op_valid = 1'b1; ld_pick = ld; st_pick = st; addr = a; st_data = sd; rt_old = rt; dest = d;
    checkOutput("opReadyAtOffer", {31'b0, op_ready}, 32'd1);
    tick();
    op_valid = 1'b0; ld_pick = '0; st_pick = '0;
  endtask

  // Hold ack low for waitCycles request cycles, then pulse it with rdata.
  task automatic runAck(input int waitCycles, input logic [31:0] rdata);
    for (int i = 0; i < waitCycles; i++) begin
      checkOutput("reqHeld", {31'b0, mem_req}, 32'd1);
      tick();
    end
    checkOutput("reqAtAck", {31'b0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = rdata;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic doLoad(input string tag, input logic [6:0] ld, input logic [31:0] a,
                        input logic [31:0] rt, input logic [4:0] d, input logic [31:0] rdata,
                        input logic [31:0] expData);
    applyStimulus(ld, 5'b0, a, 32'h0, rt, d);
    checkOutput({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
    checkOutput({tag, ".wen"}, {28'b0, mem_wen}, 32'h0);
    runAck(1, rdata);
    checkOutput({tag, ".wbValid"}, {31'b0, wb_valid}, 32'd1);
    checkOutput({tag, ".data"}, wb_data, expData);
    checkOutput({tag, ".dest"}, {27'b0, wb_dest}, {27'b0, d});
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checkOutput({tag, ".wbDone"}, {31'b0, wb_valid}, 32'd0);
    checkOutput({tag, ".ready"}, {31'b0, op_ready}, 32'd1);
  endtask

  task automatic doStore(input string tag, input logic [4:0] st, input logic [31:0] a,
                         input logic [31:0] sd, input logic [3:0] expWen,
                         input logic [31:0] expWdata);
    applyStimulus(7'b0, st, a, sd, 32'h0, 5'd0);
    checkOutput({tag, ".addr"}, mem_addr, a & 32'hFFFF_FFFC);
    checkOutput({tag, ".wen"}, {28'b0, mem_wen}, {28'b0, expWen});
    checkOutput({tag, ".wdata"}, mem_wdata, expWdata);
    runAck(0, 32'h0);
    checkOutput({tag, ".reqDrop"}, {31'b0, mem_req}, 32'd0);
    checkOutput({tag, ".ready"}, {31'b0, op_ready}, 32'd1);
    checkOutput({tag, ".noWb"}, {31'b0, wb_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    resetn = 1'b0; op_valid = 1'b0; st_pick = '0; ld_pick = '0; addr = '0; st_data = '0;
    rt_old = '0; dest = '0; mem_ack = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst.opReady", {31'b0, op_ready}, 32'd1);
    checkOutput("rst.memReq", {31'b0, mem_req}, 32'd0);
    checkOutput("rst.wbValid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rst.wen", {28'b0, mem_wen}, 32'd0);
    checkOutput("rst.wbData", wb_data, 32'd0);
    checkOutput("rst.wbExc", {31'b0, wb_exc}, 32'd0);
    resetn = 1'b1;
    tick();

    $display("[TB] T1 sw with ack after 3 request cycles");
    applyStimulus(7'b0, 5'b00001, 32'h104, 32'hAABBCCDD, 32'h0, 5'd0);
    checkOutput("T1.addr", mem_addr, 32'h104);
    checkOutput("T1.wen", {28'b0, mem_wen}, 32'hF);
    checkOutput("T1.wdata", mem_wdata, 32'hAABBCCDD);
    checkOutput("T1.busy", {31'b0, op_ready}, 32'd0);
    runAck(2, 32'h0);
    checkOutput("T1.reqDrop", {31'b0, mem_req}, 32'd0);
    checkOutput("T1.ready", {31'b0, op_ready}, 32'd1);
    checkOutput("T1.noWb", {31'b0, wb_valid}, 32'd0);

    $display("[TB] T2 byte/half loads");
    doLoad("T2.lb",  7'b0000010, 32'h203, 32'h0, 5'd3, 32'h80112233, 32'hFFFFFF80);
    doLoad("T2.lbu", 7'b0000100, 32'h203, 32'h0, 5'd4, 32'h80112233, 32'h00000080);
    doLoad("T2.lh",  7'b0001000, 32'h202, 32'h0, 5'd5, 32'h80112233, 32'hFFFF8011);
    doLoad("T2.lhu", 7'b0010000, 32'h200, 32'h0, 5'd6, 32'h80112233, 32'h00002233);
    doLoad("T2.lbA1", 7'b0000010, 32'h201, 32'h0, 5'd8, 32'h80112233, 32'h00000022);

    $display("[TB] T3 unaligned merge loads and partial stores");
    doLoad("T3.lwl1", 7'b0100000, 32'h301, 32'h11223344, 5'd9,  32'hAABBCCDD, 32'hCCDD3344);
    doLoad("T3.lwr1", 7'b1000000, 32'h301, 32'h11223344, 5'd10, 32'hAABBCCDD, 32'h11AABBCC);
    doLoad("T3.lwl0", 7'b0100000, 32'h300, 32'h11223344, 5'd11, 32'hAABBCCDD, 32'hDD223344);
    doLoad("T3.lwr2", 7'b1000000, 32'h302, 32'h11223344, 5'd12, 32'hAABBCCDD, 32'h1122AABB);
    doLoad("T3.lwl3", 7'b0100000, 32'h303, 32'h11223344, 5'd13, 32'hAABBCCDD, 32'hAABBCCDD);
    doStore("T3.swl2", 5'b01000, 32'h502, 32'h12345678, 4'b0111, 32'h00123456);
    doStore("T3.swr1", 5'b10000, 32'h501, 32'h12345678, 4'b1110, 32'h34567800);
    doStore("T3.sb2",  5'b00100, 32'h502, 32'h12345678, 4'b0100, 32'h78787878);
    doStore("T3.sh2",  5'b00010, 32'h502, 32'h12345678, 4'b1100, 32'h56785678);
    doStore("T3.sh0",  5'b00010, 32'h500, 32'h12345678, 4'b0011, 32'h56785678);

    $display("[TB] multi-hot priority and empty op");
    doLoad("MH.lbWins", 7'b0000110, 32'h203, 32'h0, 5'd14, 32'h80112233, 32'hFFFFFF80);
    op_valid = 1'b1; ld_pick = '0; st_pick = '0; addr = 32'h600;
    tick();
    op_valid = 1'b0;
    checkOutput("NOP.memReq", {31'b0, mem_req}, 32'd0);
    checkOutput("NOP.ready", {31'b0, op_ready}, 32'd1);

    $display("[TB] T4 writeback back-pressure");
    applyStimulus(7'b0000001, 5'b0, 32'h400, 32'h0, 32'h0, 5'd7);
    runAck(0, 32'hCAFEF00D);
    op_valid = 1'b1; st_pick = 5'b00001; addr = 32'h700; st_data = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      checkOutput("T4.wbValid", {31'b0, wb_valid}, 32'd1);
      checkOutput("T4.data", wb_data, 32'hCAFEF00D);
      checkOutput("T4.dest", {27'b0, wb_dest}, 32'd7);
      checkOutput("T4.busy", {31'b0, op_ready}, 32'd0);
      checkOutput("T4.noReq", {31'b0, mem_req}, 32'd0);
      tick();
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0; op_valid = 1'b0; st_pick = '0;
    checkOutput("T4.wbDone", {31'b0, wb_valid}, 32'd0);
    checkOutput("T4.notTaken", {31'b0, mem_req}, 32'd0);
    checkOutput("T4.ready", {31'b0, op_ready}, 32'd1);

    $display("[TB] T5 reset while requesting");
    applyStimulus(7'b0000001, 5'b0, 32'h800, 32'h0, 32'h0, 5'd2);
    checkOutput("T5.inReq", {31'b0, mem_req}, 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("T5.abortReq", {31'b0, mem_req}, 32'd0);
    checkOutput("T5.abortReady", {31'b0, op_ready}, 32'd1);
    tick();
    resetn = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    checkOutput("T5.memReq", {31'b0, mem_req}, 32'd0);
    checkOutput("T5.ready", {31'b0, op_ready}, 32'd1);
    checkOutput("T5.noWb", {31'b0, wb_valid}, 32'd0);

    $display("[TB] T6 misaligned lw");
`ifdef MEM_ALIGN_EXC_EN
    applyStimulus(7'b0000001, 5'b0, 32'h102, 32'h0, 32'h0, 5'd15);
    checkOutput("T6.noReq", {31'b0, mem_req}, 32'd0);
    checkOutput("T6.wbValid", {31'b0, wb_valid}, 32'd1);
    checkOutput("T6.exc", {31'b0, wb_exc}, 32'd1);
    checkOutput("T6.badAddr", wb_data, 32'h102);
    checkOutput("T6.dest", {27'b0, wb_dest}, 32'd15);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checkOutput("T6.ready", {31'b0, op_ready}, 32'd1);
`else
    doLoad("T6.lw", 7'b0000001, 32'h102, 32'h0, 5'd15, 32'h5A5AA5A5, 32'h5A5AA5A5);
    checkOutput("T6.exc", {31'b0, wb_exc}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
